// File: rtl/prf_bypass_regfile_pkg.sv
// prf_bypass_regfile_pkg
//   Shared definitions for the physical register file. It holds the default
//   widths and counts, the hardwired-zero tag, and the CDB tag packet type.
//   It has no ports.
package prf_bypass_regfile_pkg;

   localparam int DEF_XLEN      = 32;
   localparam int DEF_NUM_PR    = 64;
   localparam int DEF_PRW       = $clog2(DEF_NUM_PR);
   localparam int DEF_NUM_WR    = 3;
   localparam int DEF_NUM_RD    = 6;
   localparam int DEF_NUM_ALLOC = 3;
   localparam int DEF_ZERO_PR   = 0;

   // One CDB broadcast slot: a valid bit plus the destination tag.
   typedef struct packed {
      logic               valid;
      logic [DEF_PRW-1:0] tag;
   } cdb_tag_t;

   // Full CDB tag packet, with one slot per write port.
   typedef cdb_tag_t [DEF_NUM_WR-1:0] cdb_pkt_t;

endpackage

// File: rtl/prf_bypass_regfile_ready_table.sv
// prf_ready_table
//   Per-physical-register ready bits.
//   - A CDB write sets the bit.
//   - A dispatch allocation clears it; when both hit the same tag, the
//     allocation wins.
//   - Reset sets every bit to 1.
//   - The zero register is always ready.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   wr_en, wr_idx     : CDB write valids and tags
//   alloc_en/alloc_idx: allocation valids and tags
//   ready             : registered ready vector, one bit per physical register
module prf_ready_table
   import prf_bypass_regfile_pkg::*;
#(
   parameter int NUM_PR    = DEF_NUM_PR,
   parameter int NUM_WR    = DEF_NUM_WR,
   parameter int NUM_ALLOC = DEF_NUM_ALLOC,
   parameter int ZERO_PR   = DEF_ZERO_PR,
   parameter int PRW       = $clog2(NUM_PR)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR-1:0][PRW-1:0]      wr_idx,
   input  logic [NUM_ALLOC-1:0]            alloc_en,
   input  logic [NUM_ALLOC-1:0][PRW-1:0]   alloc_idx,
   output logic [NUM_PR-1:0]               ready
);

   localparam logic [PRW-1:0] ZTAG = ZERO_PR[PRW-1:0];

   logic [NUM_PR-1:0] ready_nxt;

   // Sets are applied first and clears last, so allocation has priority.
   always_comb begin
      ready_nxt = ready;
      for (int p = 0; p < NUM_WR; p++)
         if (wr_en[p] && wr_idx[p] != ZTAG) ready_nxt[wr_idx[p]] = 1'b1;
      for (int a = 0; a < NUM_ALLOC; a++)
         if (alloc_en[a] && alloc_idx[a] != ZTAG) ready_nxt[alloc_idx[a]] = 1'b0;
      ready_nxt[ZTAG] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) ready <= '1;
      else       ready <= ready_nxt;
   end

endmodule

// File: rtl/prf_bypass_regfile.sv
// prf_bypass_regfile
//   Physical register file with per-register ready bits and an optional
//   same-cycle write-to-read bypass.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   wr_en/wr_idx/wr_data : NUM_WR CDB write ports; on a tag collision the
//                          highest port wins
//   alloc_en/alloc_idx : NUM_ALLOC dispatch allocations; each clears ready
//                        for the next cycle
//   rd_idx             : NUM_RD read tags
//   rd_data/rd_ready   : combinational read data and ready
module prf_bypass_regfile
   import prf_bypass_regfile_pkg::*;
#(
   parameter int NUM_PR    = DEF_NUM_PR,
   parameter int XLEN      = DEF_XLEN,
   parameter int NUM_WR    = DEF_NUM_WR,
   parameter int NUM_RD    = DEF_NUM_RD,
   parameter int NUM_ALLOC = DEF_NUM_ALLOC,
   parameter int BYPASS    = 1,
   parameter int ZERO_PR   = DEF_ZERO_PR,
   parameter int PRW       = $clog2(NUM_PR)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR-1:0][PRW-1:0]      wr_idx,
   input  logic [NUM_WR-1:0][XLEN-1:0]     wr_data,
   input  logic [NUM_ALLOC-1:0]            alloc_en,
   input  logic [NUM_ALLOC-1:0][PRW-1:0]   alloc_idx,
   input  logic [NUM_RD-1:0][PRW-1:0]      rd_idx,
   output logic [NUM_RD-1:0][XLEN-1:0]     rd_data,
   output logic [NUM_RD-1:0]               rd_ready
);

   localparam logic [PRW-1:0] ZTAG = ZERO_PR[PRW-1:0];

   logic [XLEN-1:0]   regs [NUM_PR];
   logic [NUM_PR-1:0] ready;

   prf_ready_table #(
      .NUM_PR    (NUM_PR),
      .NUM_WR    (NUM_WR),
      .NUM_ALLOC (NUM_ALLOC),
      .ZERO_PR   (ZERO_PR),
      .PRW       (PRW)
   ) u_ready (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .alloc_en  (alloc_en),
      .alloc_idx (alloc_idx),
      .ready     (ready)
   );

   // Ports are walked in ascending order, so the highest colliding port
   // makes the last assignment and wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_PR; i++) regs[i] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p] && wr_idx[p] != ZTAG) regs[wr_idx[p]] <= wr_data[p];
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic            hit;
      logic [XLEN-1:0] data;

      // Bypass is suppressed during reset, because those writes are being
      // discarded.
      always_comb begin
         hit  = 1'b0;
         data = regs[rd_idx[r]];
         if (BYPASS != 0 && !reset)
            for (int p = 0; p < NUM_WR; p++)
               if (wr_en[p] && wr_idx[p] == rd_idx[r] && wr_idx[p] != ZTAG) begin
                  hit  = 1'b1;
                  data = wr_data[p];
               end
      end

      assign rd_data[r]  = (rd_idx[r] == ZTAG) ? '0   : data;
      assign rd_ready[r] = (rd_idx[r] == ZTAG) ? 1'b1 : (hit | ready[rd_idx[r]]);
   end

endmodule
